debug_scan_master: RTL and testbench
====================================

Name: debug_scan_master

Overview:
- Clock-domain scan initiator that drives the virtual-JTAG side of the CPU debug slave.
- Replaces the host/TAP for on-chip self-test and for simulation, where the virtual JTAG physical layer is tied off.
- Accepts one scan command (IR value plus DR word), then generates the full UIR/CDR/SDR/UDR/RTI sequence with a divided tck.
- Returns the DR word captured from tdo.

Parameters:
- DR_WIDTH, 38, data-register scan length in bits.
- IR_WIDTH, 2, instruction width driven on ir_in.
- TCK_HALF, 2, tck half-period in clk cycles (>=1).
- RTI_CYCLES, 2, tck periods spent in run-test-idle after UDR (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_data  in  DR_WIDTH  word to shift in, LSB first.
- rsp_valid  out  1  captured word available.
- rsp_ready  in  1  response accept.
- rsp_data  out  DR_WIDTH  word captured from tdo.
- busy  out  1  high from accept until the response is taken.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  instruction presented to slave.
- vji_ir_out  in  IR_WIDTH  slave IR status, captured at UIR.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1  virtual state strobes.
- ir_status  out  IR_WIDTH  vji_ir_out sampled during UIR.

Behaviour:
- Reset values: all outputs 0, cmd_ready=1, FSM=IDLE, divider=0.
  - Async reset mid-scan aborts immediately; no response is produced.
- Every output is registered.
- tck divider: runs only outside IDLE/RESP.
  - tck low for TCK_HALF clk cycles, then high for TCK_HALF.
  - rise_en = clk cycle in which tck goes 0->1; fall_en = cycle in which it goes 1->0.
- Each tck period begins with tck low.
  - State changes and strobe/tdi updates happen at period start (the fall_en edge, or the accept edge for the first period).
- FSM states: IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
  - IDLE: cmd_valid&cmd_ready -> latch cmd_ir into vji_ir_in and cmd_data into shreg, go UIR, busy=1.
  - UIR: 1 tck period, vji_uir=1; ir_status <= vji_ir_out at rise_en.
  - CDR: 1 period, vji_cdr=1.
  - SDR: DR_WIDTH periods, vji_sdr=1.
    - vji_tdi = shreg[0], updated at period start.
    - At rise_en: shreg <= {vji_tdo, shreg[DR_WIDTH-1:1]}; bit counter increments.
    - Exit after exactly DR_WIDTH rising edges; the counter wraps to 0 only on entry.
  - UDR: 1 period, vji_udr=1, tdi=0.
  - RTI: RTI_CYCLES periods, vji_rti=1.
  - RTI -> RESP at the end of the last RTI period: tck held 0, rsp_data=shreg, rsp_valid=1.
  - RESP: hold rsp_valid/rsp_data stable until rsp_ready; on handshake -> IDLE, busy=0, cmd_ready=1 next cycle.
- vji_ir_in holds the latched value from UIR through RESP; it is cleared to 0 on return to IDLE.
- Strobes are one-hot; at most one is high in any cycle.
- Latency: accept edge -> rsp_valid = (3+DR_WIDTH+RTI_CYCLES)*2*TCK_HALF clk cycles. Defaults give 172.
- cmd_valid while busy is ignored; no queueing. The command bus is sampled only at accept.
- rsp_ready asserted outside RESP has no effect.
- A command is accepted no earlier than the cycle after IDLE is re-entered.

Decomposition:
- Shared package debug_scan_pkg:
  - FSM state enum.
  - Default DR_WIDTH/IR_WIDTH constants.
  - IR opcode constants: 00 ocimem, 01 break_a, 10 break_b/trace, 11 break_c.
- One sub-module: debug_scan_tck_gen (divider producing vji_tck, rise_en, fall_en, with run enable).
- Shift register and FSM stay in the top.

Test Plan:
- Loopback (tdo=tdi via a one-tck-delay model), cmd_ir=01, cmd_data=0x2A5A5A5A5 -> rsp_data equals the model's shifted result; 38 tck rising edges while vji_sdr=1; ir_in=01 throughout.
- tdo tied 1, cmd_data=0 -> rsp_data=0x3FFFFFFFFF; tdo tied 0 -> rsp_data=0x0; rsp_valid exactly 172 clk after the accept edge.
- Strobe order and duration: UIR, CDR and UDR each 4 clk; SDR 152 clk; RTI 8 clk. Never two strobes high at once; ir_status captures vji_ir_out=10.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid/rsp_data stable, tck stays low; a second cmd_valid during busy is not accepted.
- Reset asserted at SDR bit 17 -> all outputs 0 within the same cycle; the next command completes normally with a correct capture.
- TCK_HALF=1, RTI_CYCLES=1 -> latency (3+38+1)*2=84 clk; capture still correct.

Source files
------------

// File: rtl/debug_scan_pkg.sv
// Shared types and constants for the debug scan master.
package debug_scan_pkg;

    localparam int DEFAULT_DR_WIDTH = 38;
    localparam int DEFAULT_IR_WIDTH = 2;

    // Debug slave instruction opcodes.
    localparam logic [1:0] OP_OCIMEM  = 2'b00;
    localparam logic [1:0] OP_BREAK_A = 2'b01;
    localparam logic [1:0] OP_BREAK_B = 2'b10; // also selects trace
    localparam logic [1:0] OP_BREAK_C = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RTI  = 3'd5,
        S_RESP = 3'd6
    } scan_state_e;

endpackage

// File: rtl/debug_scan_master_tck_gen.sv
// Divided test clock: TCK_HALF clk cycles low, then TCK_HALF high, while run is set.
// rise_en/fall_en flag the clk cycle whose closing edge moves tck 0->1 / 1->0.
module debug_scan_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tck,
    output logic rise_en,
    output logic fall_en
);

    localparam int CW = (TCK_HALF > 1) ? $clog2(2 * TCK_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;

    // Phase counter and tck level; both park at 0 whenever run drops.
    always_comb begin
        rise_en = run && (cnt_q == CW'(TCK_HALF - 1));
        fall_en = run && (cnt_q == CW'(2 * TCK_HALF - 1));
        cnt_d   = '0;
        tck_d   = 1'b0;
        if (run) begin
            cnt_d = fall_en ? '0 : cnt_q + 1'b1;
            if (rise_en)      tck_d = 1'b1;
            else if (fall_en) tck_d = 1'b0;
            else              tck_d = tck_q;
        end
    end

    // Divider state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck = tck_q;

endmodule

// File: rtl/debug_scan_master.sv
// Scan initiator: one command (IR + DR word) produces a full UIR/CDR/SDR/UDR/RTI
// sequence on the virtual JTAG side and returns the DR word captured from tdo.
//
// Handshakes: a transfer happens on a clk edge where valid and ready are both high.
// cmd_ready is high only in IDLE; the command bus is sampled only on that edge.
// rsp_valid holds, with rsp_data stable, until the edge where rsp_ready is high.
module debug_scan_master
    import debug_scan_pkg::*;
#(
    parameter int DR_WIDTH   = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH   = DEFAULT_IR_WIDTH,
    parameter int TCK_HALF   = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic [IR_WIDTH-1:0] ir_status,
    output logic [2:0]          dbg_state
);

    localparam int BCW = $clog2(DR_WIDTH + 1);
    localparam int RCW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

    scan_state_e         state_q, state_d;
    logic [DR_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [RCW-1:0]      rti_cnt_q, rti_cnt_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [IR_WIDTH-1:0] ir_status_q, ir_status_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                tdi_q, tdi_d;
    logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;
    logic                rsp_valid_q, rsp_valid_d, busy_q, busy_d, cmd_ready_q, cmd_ready_d;
    logic                accept;
    logic                run, rise_en, fall_en;

    // The divider only runs while a scan sequence is on the wire.
    assign run = (state_q != S_IDLE) && (state_q != S_RESP);

    debug_scan_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
        .clk     (clk),
        .rst     (reset),
        .run     (run),
        .tck     (vji_tck),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    // Next-state, shifter and output decode; state changes only at tck period starts.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        rti_cnt_d   = rti_cnt_q;
        ir_in_d     = ir_in_q;
        ir_status_d = ir_status_q;
        rsp_data_d  = rsp_data_q;
        tdi_d       = tdi_q;
        accept      = 1'b0;
        unique case (state_q)
            S_IDLE: if (cmd_valid) begin
                accept  = 1'b1;
                state_d = S_UIR;
                ir_in_d = cmd_ir;
                shreg_d = cmd_data;
            end
            S_UIR: begin
                if (rise_en) ir_status_d = vji_ir_out;
                if (fall_en) state_d = S_CDR;
            end
            S_CDR: if (fall_en) begin
                state_d   = S_SDR;
                bit_cnt_d = '0;
            end
            S_SDR: begin
                if (rise_en) begin
                    shreg_d   = {vji_tdo, shreg_q[DR_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (fall_en && (bit_cnt_q == BCW'(DR_WIDTH))) state_d = S_UDR;
            end
            S_UDR: if (fall_en) begin
                state_d   = S_RTI;
                rti_cnt_d = '0;
            end
            S_RTI: if (fall_en) begin
                if (rti_cnt_q == RCW'(RTI_CYCLES - 1)) begin
                    state_d    = S_RESP;
                    rsp_data_d = shreg_q;
                end else begin
                    rti_cnt_d = rti_cnt_q + 1'b1;
                end
            end
            S_RESP: if (rsp_ready) begin
                state_d = S_IDLE;
                ir_in_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // tdi changes only at a period start; it carries data only inside SDR.
        if (accept || fall_en) tdi_d = (state_d == S_SDR) ? shreg_q[0] : 1'b0;
        uir_d       = (state_d == S_UIR);
        cdr_d       = (state_d == S_CDR);
        sdr_d       = (state_d == S_SDR);
        udr_d       = (state_d == S_UDR);
        rti_d       = (state_d == S_RTI);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset aborts any scan in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            rti_cnt_q   <= '0;
            ir_in_q     <= '0;
            ir_status_q <= '0;
            rsp_data_q  <= '0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            rti_cnt_q   <= rti_cnt_d;
            ir_in_q     <= ir_in_d;
            ir_status_q <= ir_status_d;
            rsp_data_q  <= rsp_data_d;
            tdi_q       <= tdi_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            rti_q       <= rti_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;
    assign vji_rti   = rti_q;
    assign ir_status = ir_status_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_debug_scan_master.sv
// Directed bench for debug_scan_master: default instance plus a fast-tck instance.
module tb_debug_scan_master;
  import debug_scan_pkg::*;

  localparam int DW = 38;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- default instance ----------------
  logic          cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, busy;
  logic [IW-1:0] cmd_ir = '0, vji_ir_in, vji_ir_out = '0, ir_status;
  logic [DW-1:0] cmd_data = '0, rsp_data;
  logic          vji_tck, vji_tdi, vji_tdo;
  logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [2:0]    dbg_state;
  int            tdo_mode = 0;  // 0: tied 0, 1: tied 1, 2: loopback
  logic          loop_q = 1'b0;

  always @(posedge vji_tck) loop_q <= vji_tdi;
  assign vji_tdo = (tdo_mode == 2) ? loop_q : (tdo_mode == 1);

  debug_scan_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
    .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
    .vji_rti(vji_rti), .ir_status(ir_status), .dbg_state(dbg_state)
  );

  // ---------------- fast instance (TCK_HALF=1, RTI_CYCLES=1) ----------------
  logic          f_cmd_valid = 1'b0, f_cmd_ready, f_rsp_valid, f_rsp_ready = 1'b0, f_busy;
  logic [IW-1:0] f_cmd_ir = '0, f_ir_in, f_ir_out = '0, f_ir_status;
  logic [DW-1:0] f_cmd_data = '0, f_rsp_data;
  logic          f_tck, f_tdi, f_tdo, f_uir, f_cdr, f_sdr, f_udr, f_rti;
  logic [2:0]    f_dbg_state;
  logic          f_loop_q = 1'b0;

  always @(posedge f_tck) f_loop_q <= f_tdi;
  assign f_tdo = f_loop_q;

  debug_scan_master #(.TCK_HALF(1), .RTI_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_ir(f_cmd_ir), .cmd_data(f_cmd_data), .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready),
    .rsp_data(f_rsp_data), .busy(f_busy), .vji_tck(f_tck), .vji_tdi(f_tdi),
    .vji_tdo(f_tdo), .vji_ir_in(f_ir_in), .vji_ir_out(f_ir_out),
    .vji_uir(f_uir), .vji_cdr(f_cdr), .vji_sdr(f_sdr), .vji_udr(f_udr),
    .vji_rti(f_rti), .ir_status(f_ir_status), .dbg_state(f_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- protocol monitor ----------------
  logic [4:0]    strb;
  int            str_n[5];
  int            str_first[5];
  int            multi_err = 0, ir_err = 0, sdr_rise = 0, acc_cyc = 0;
  logic [IW-1:0] mon_ir = '0;
  logic          tck_prev = 1'b0;

  assign strb = {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir};

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      for (int i = 0; i < 5; i++) begin
        str_n[i] = 0;
        str_first[i] = -1;
      end
      multi_err = 0;
      ir_err = 0;
      sdr_rise = 0;
      acc_cyc = cyc + 1;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (strb[i]) begin
          str_n[i]++;
          if (str_first[i] < 0) str_first[i] = cyc - acc_cyc;
        end
      end
      if ($countones(strb) > 1) multi_err++;
      if (vji_tck && !tck_prev && vji_sdr) sdr_rise++;
      if (busy && vji_ir_in !== mon_ir) ir_err++;
    end
    tck_prev = vji_tck;
  end

  // ---------------- driver ----------------
  int stab_err = 0;

  task automatic do_scan(input logic [IW-1:0] ir, input logic [DW-1:0] data, input int hold,
                         output logic [DW-1:0] got, output int lat);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_data  = data;
    mon_ir    = ir;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_ir    = ~ir;
    cmd_data  = ~data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 1000);
    if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
    lat = cyc - acc_cyc;
    got = rsp_data;
    stab_err = 0;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== got || vji_tck !== 1'b0) stab_err++;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] got;
  int            lat;
  int            exp_n[5] = '{4, 4, 152, 4, 8};
  int            exp_first[5] = '{0, 4, 8, 160, 164};
  int            n;
  int            f_acc;

  initial begin
    // reset values
    #12;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_outputs", {rsp_valid, busy, vji_tck, vji_tdi, strb, vji_ir_in, ir_status, dbg_state, rsp_data}, 0);
    check("reset_fast_ready", f_cmd_ready, 1);
    #10 reset = 1'b0;

    // 1: loopback, ir = break_a
    tdo_mode = 2;
    vji_ir_out = 2'b01;
    do_scan(OP_BREAK_A, 38'h2A5A5A5A5, 0, got, lat);
    check("loop_data", got, 38'h54B4B4B4A);
    check("loop_latency", lat, 172);
    check("loop_sdr_rises", sdr_rise, 38);
    check("loop_ir_in_hold", ir_err, 0);
    check("loop_ir_status", ir_status, 2'b01);

    // 2: tdo tied 1, strobe order/duration, ir_status capture
    tdo_mode = 1;
    vji_ir_out = 2'b10;
    do_scan(OP_BREAK_B, 38'h0, 0, got, lat);
    check("ones_data", got, 38'h3FFFFFFFFF);
    check("ones_latency", lat, 172);
    check("ones_ir_status", ir_status, 2'b10);
    check("strobe_onehot", multi_err, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("strobe%0d_len", i), str_n[i], exp_n[i]);
      check($sformatf("strobe%0d_start", i), str_first[i], exp_first[i]);
    end
    @(negedge clk);
    check("idle_ir_in_cleared", vji_ir_in, 0);

    // 3: tdo tied 0
    tdo_mode = 0;
    do_scan(OP_OCIMEM, 38'h3FFFFFFFFF, 0, got, lat);
    check("zeros_data", got, 38'h0);
    check("zeros_latency", lat, 172);

    // 4: backpressure and a second command while busy
    tdo_mode = 1;
    fork
      do_scan(OP_BREAK_C, 38'h0, 5, got, lat);
      begin
        repeat (20) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_data  = 38'h15;
        cmd_ir    = OP_OCIMEM;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
      end
    join
    check("bp_data", got, 38'h3FFFFFFFFF);
    check("bp_stable", stab_err, 0);
    @(negedge clk);
    check("bp_busy_after", busy, 0);
    check("bp_ready_after", cmd_ready, 1);
    repeat (10) @(negedge clk);
    check("bp_no_second_scan", {busy, vji_tck, strb}, 0);

    // 5: reset in the middle of SDR
    tdo_mode = 2;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_ir    = OP_BREAK_B;
    cmd_data  = 38'h2AAAAAAAAA;
    mon_ir    = OP_BREAK_B;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sdr_rise < 17 && n < 1000);
    check("rst_reached_bit17", sdr_rise >= 17, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_outputs", {rsp_valid, busy, vji_tck, vji_tdi, strb, vji_ir_in, ir_status, dbg_state, rsp_data}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    do_scan(OP_BREAK_A, 38'h0F0F0F0F0F, 0, got, lat);
    check("post_rst_data", got, 38'h1E1E1E1E1E);
    check("post_rst_latency", lat, 172);

    // 6: fast instance latency and capture
    @(posedge clk); #1;
    f_cmd_valid = 1'b1;
    f_cmd_ir    = OP_BREAK_B;
    f_cmd_data  = 38'h2A5A5A5A5;
    f_acc       = cyc + 1;
    @(posedge clk); #1;
    f_cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!f_rsp_valid && n < 500);
    check("fast_latency", cyc - f_acc, 84);
    check("fast_data", f_rsp_data, 38'h54B4B4B4A);
    @(posedge clk); #1;
    f_rsp_ready = 1'b1;
    @(posedge clk); #1;
    f_rsp_ready = 1'b0;
    @(negedge clk);
    check("fast_idle", {f_busy, f_cmd_ready}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
